// File: rtl/lookup_cfg_ctrl_pkg.sv
// Shared widths, op/state encodings and the registered command for the stage config sequencer.
// Entry count must stay a power of two so every cmd_addr maps to a real entry.
package lookup_cfg_ctrl_pkg;

    localparam int KEY_W        = 256;
    localparam int DEPTH        = 16;
    localparam int ADDR_W       = 4;
    localparam int ACT_W        = 625;
    localparam int BUSY_TIMEOUT = 64;

    localparam logic [DEPTH-1:0] INIT_VALID = '0;

    typedef enum logic [1:0] {
        OP_CAM   = 2'b00,
        OP_ACT   = 2'b01,
        OP_ENTRY = 2'b10,
        OP_INVAL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_QUIESCE  = 3'd1,
        ST_ACT_WR   = 3'd2,
        ST_CAM_WR   = 3'd3,
        ST_CAM_WAIT = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERR      = 3'd6
    } state_e;

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] addr;
        logic [KEY_W-1:0]  key;
        logic [KEY_W-1:0]  mask;
        logic [ACT_W-1:0]  act;
    } cmd_t;

    function automatic logic op_has_act(input op_e op);
        return (op == OP_ACT) || (op == OP_ENTRY);
    endfunction

    function automatic logic op_sets_valid(input op_e op);
        return (op == OP_CAM) || (op == OP_ENTRY);
    endfunction

endpackage

// File: rtl/lookup_cfg_ctrl_if.sv
// Command, lookup-quiesce, CAM write and action-RAM port-A signals of one match-action stage.
// slave = the config controller, master = the parser/stage side that drives commands and status.
interface lookup_cfg_ctrl_if;
    import lookup_cfg_ctrl_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [KEY_W-1:0]  cmd_key;
    logic [KEY_W-1:0]  cmd_mask;
    logic [ACT_W-1:0]  cmd_act;

    logic              lkup_inflight;
    logic              lkup_hold;

    logic              cam_we;
    logic [ADDR_W-1:0] cam_wr_addr;
    logic [KEY_W-1:0]  cam_din;
    logic [KEY_W-1:0]  cam_data_mask;
    logic              cam_busy;

    logic              act_we;
    logic [ADDR_W-1:0] act_addr;
    logic [ACT_W-1:0]  act_din;

    logic [DEPTH-1:0]  entry_valid;
    logic              cmd_done;
    logic              cmd_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_key, cmd_mask, cmd_act,
        input  lkup_inflight, cam_busy,
        output cmd_ready, lkup_hold,
        output cam_we, cam_wr_addr, cam_din, cam_data_mask,
        output act_we, act_addr, act_din,
        output entry_valid, cmd_done, cmd_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_key, cmd_mask, cmd_act,
        output lkup_inflight, cam_busy,
        input  cmd_ready, lkup_hold,
        input  cam_we, cam_wr_addr, cam_din, cam_data_mask,
        input  act_we, act_addr, act_din,
        input  entry_valid, cmd_done, cmd_err
    );

endinterface

// File: rtl/lookup_cfg_ctrl_wait_timer.sv
// Clear/enable up-counter bounding the CAM busy wait; tc_o flags count == LIMIT-1.
// Counts from 0 the cycle after clear drops; holds at terminal count rather than wrapping.
module lookup_cfg_ctrl_wait_timer #(
    parameter int LIMIT = 64,
    parameter int CNT_W = $clog2(LIMIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic started_o,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc_o      = (cnt_q == CNT_W'(LIMIT - 1));
    assign started_o = (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lookup_cfg_ctrl.sv
// Quiesces the lookup path, then writes action RAM before CAM key so a hit never sees a stale action.
// One command at a time: cmd_ready only in IDLE; ACT_ONLY done at c3, CAM write done >= c5.
module lookup_cfg_ctrl
    import lookup_cfg_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    lookup_cfg_ctrl_if.slave cfg
);

    state_e           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic [DEPTH-1:0] valid_q, valid_d;

    logic tmr_clr, tmr_en, tmr_started, tmr_tc;
    op_e  in_op;

    assign in_op = op_e'(cfg.cmd_op);

    lookup_cfg_ctrl_wait_timer #(
        .LIMIT (BUSY_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .started_o (tmr_started),
        .tc_o      (tmr_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            valid_q <= INIT_VALID;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        valid_d       = valid_q;
        tmr_clr       = 1'b1;
        tmr_en        = 1'b0;
        cfg.cmd_ready = 1'b0;
        cfg.lkup_hold = 1'b1;
        cfg.act_we    = 1'b0;
        cfg.cam_we    = 1'b0;
        cfg.cmd_done  = 1'b0;
        cfg.cmd_err   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cfg.cmd_ready = 1'b1;
                cfg.lkup_hold = 1'b0;
                if (cfg.cmd_valid) begin
                    cmd_d.op   = in_op;
                    cmd_d.addr = cfg.cmd_addr;
                    cmd_d.act  = cfg.cmd_act;
                    // Invalidate overwrites the slot with the reserved never-match key.
                    if (in_op == OP_INVAL) begin
                        cmd_d.key  = {KEY_W{1'b1}};
                        cmd_d.mask = '0;
                    end else begin
                        cmd_d.key  = cfg.cmd_key;
                        cmd_d.mask = cfg.cmd_mask;
                    end
                    state_d = ST_QUIESCE;
                end
            end

            ST_QUIESCE: begin
                if (!cfg.lkup_inflight) begin
                    state_d = op_has_act(cmd_q.op) ? ST_ACT_WR : ST_CAM_WR;
                end
            end

            ST_ACT_WR: begin
                cfg.act_we = 1'b1;
                state_d    = (cmd_q.op == OP_ENTRY) ? ST_CAM_WR : ST_DONE;
            end

            ST_CAM_WR: begin
                cfg.cam_we = 1'b1;
                state_d    = ST_CAM_WAIT;
            end

            // Busy may only rise the cycle after WE, so the first wait cycle never exits.
            ST_CAM_WAIT: begin
                tmr_clr = 1'b0;
                tmr_en  = 1'b1;
                if (tmr_started && !cfg.cam_busy) begin
                    state_d = ST_DONE;
                end else if (tmr_tc) begin
                    state_d = ST_ERR;
                end
            end

            ST_DONE: begin
                cfg.cmd_done = 1'b1;
                if (op_sets_valid(cmd_q.op)) begin
                    valid_d[cmd_q.addr] = 1'b1;
                end else if (cmd_q.op == OP_INVAL) begin
                    valid_d[cmd_q.addr] = 1'b0;
                end
                state_d = ST_IDLE;
            end

            ST_ERR: begin
                cfg.cmd_err = 1'b1;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cfg.cam_wr_addr   = '0;
        cfg.cam_din       = '0;
        cfg.cam_data_mask = '0;
        cfg.act_addr      = '0;
        cfg.act_din       = '0;
        if (state_q != ST_IDLE) begin
            cfg.cam_wr_addr   = cmd_q.addr;
            cfg.cam_din       = cmd_q.key;
            cfg.cam_data_mask = cmd_q.mask;
            cfg.act_addr      = cmd_q.addr;
            cfg.act_din       = cmd_q.act;
        end
    end

    assign cfg.entry_valid = valid_q;

endmodule
